hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Drives write-enable, flush and hold controls for the PC and for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three conditions: load-use hazards, taken branches resolved in MEM, and data-memory wait states.
- A timeout FSM halts the core on a stuck memory; saturating counters record stalls and flushes for performance debug.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    // Sequencer states; encoding is fixed so debug probes can decode it directly.
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

    // Architectural zero register: writes to it never create a dependency.
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Bits needed to count 0..value-1 (at least one bit).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        if (width == 0) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts INC pulses, sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 INC,
    output logic [CNT_WIDTH-1:0] COUNT
);

    logic [CNT_WIDTH-1:0] count_q;

    // Synchronous clear; increment only while below the saturation value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else if (INC && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign COUNT = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes,
// data-memory wait states with timeout halt, and stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [4:0]           ID_RS,
    input  logic [4:0]           ID_RT,
    input  logic                 ID_USES_RT,
    input  logic                 EX_MEM_READ,
    input  logic [4:0]           EX_RT,
    input  logic                 MEM_BRANCH_TAKEN,
    input  logic                 MEM_ACCESS,
    input  logic                 DMEM_READY,
    input  logic                 HALT_REQ,
    output logic                 PC_WRITE,
    output logic                 IF_ID_WRITE,
    output logic                 IF_ID_FLUSH,
    output logic                 ID_EX_FLUSH,
    output logic                 EX_MEM_FLUSH,
    output logic                 PIPE_HOLD,
    output logic                 PC_SRC_BRANCH,
    output logic                 MEM_ERROR,
    output logic [CNT_WIDTH-1:0] STALL_COUNT,
    output logic [CNT_WIDTH-1:0] FLUSH_COUNT
);

    localparam int unsigned TimerW = clog2(TIMEOUT);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              mem_error_q, mem_error_d;
    logic              stall_inc, flush_inc;
    logic              load_use;

    // Load in EX feeds a source of the instruction in ID; r0 never hazards.
    assign load_use = EX_MEM_READ && (EX_RT != ZERO_REG) &&
                      ((EX_RT == ID_RS) || (ID_USES_RT && (EX_RT == ID_RT)));

    // Control outputs and next state from registered state plus current inputs.
    always_comb begin
        PC_WRITE      = 1'b1;
        IF_ID_WRITE   = 1'b1;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_FLUSH   = 1'b0;
        EX_MEM_FLUSH  = 1'b0;
        PIPE_HOLD     = 1'b0;
        PC_SRC_BRANCH = 1'b0;
        state_d       = state_q;
        timer_d       = timer_q;
        mem_error_d   = mem_error_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (RESET) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (MEM_ACCESS && !DMEM_READY) begin
                        PIPE_HOLD   = 1'b1;
                        PC_WRITE    = 1'b0;
                        IF_ID_WRITE = 1'b0;
                        stall_inc   = 1'b1;
                        timer_d     = TimerW'(1);
                        state_d     = StMemWait;
                    end else if (MEM_BRANCH_TAKEN) begin
                        // Flush also discards any load-use pending in ID.
                        PC_SRC_BRANCH = 1'b1;
                        IF_ID_FLUSH   = 1'b1;
                        ID_EX_FLUSH   = 1'b1;
                        EX_MEM_FLUSH  = 1'b1;
                        flush_inc     = 1'b1;
                    end else if (load_use) begin
                        PC_WRITE    = 1'b0;
                        IF_ID_WRITE = 1'b0;
                        ID_EX_FLUSH = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (HALT_REQ) begin
                        // Halt entry belongs to the halt, not to stall accounting.
                        PC_WRITE    = 1'b0;
                        IF_ID_WRITE = 1'b0;
                        ID_EX_FLUSH = 1'b1;
                        state_d     = StHalt;
                    end
                end
                StMemWait: begin
                    if (DMEM_READY) begin
                        state_d = StRun;
                        timer_d = '0;
                    end else begin
                        PIPE_HOLD   = 1'b1;
                        PC_WRITE    = 1'b0;
                        IF_ID_WRITE = 1'b0;
                        stall_inc   = 1'b1;
                        timer_d     = timer_q + 1'b1;
                        if (timer_q == TimerLast) begin
                            mem_error_d = 1'b1;
                            state_d     = StHalt;
                        end
                    end
                end
                StHalt: begin
                    PC_WRITE    = 1'b0;
                    IF_ID_WRITE = 1'b0;
                    PIPE_HOLD   = 1'b1;
                end
                default: begin
                    state_d = StRun;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Sequencer state, wait timer and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StRun;
            timer_q     <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign MEM_ERROR = mem_error_q;

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .CLK  (CLK),
        .RESET(RESET),
        .INC  (stall_inc),
        .COUNT(STALL_COUNT)
    );

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_flush_cnt (
        .CLK  (CLK),
        .RESET(RESET),
        .INC  (flush_inc),
        .COUNT(FLUSH_COUNT)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic.
module tb_hazard_ctrl;

    localparam int unsigned TO  = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          uses_rt, ex_rd, br, acc, rdy, halt;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic          pipe_hold, pc_src, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .TIMEOUT  (TO),
        .CNT_WIDTH(CW)
    ) dut (
        .CLK             (clk),
        .RESET           (rst),
        .ID_RS           (id_rs),
        .ID_RT           (id_rt),
        .ID_USES_RT      (uses_rt),
        .EX_MEM_READ     (ex_rd),
        .EX_RT           (ex_rt),
        .MEM_BRANCH_TAKEN(br),
        .MEM_ACCESS      (acc),
        .DMEM_READY      (rdy),
        .HALT_REQ        (halt),
        .PC_WRITE        (pc_write),
        .IF_ID_WRITE     (if_id_write),
        .IF_ID_FLUSH     (if_id_flush),
        .ID_EX_FLUSH     (id_ex_flush),
        .EX_MEM_FLUSH    (ex_mem_flush),
        .PIPE_HOLD       (pipe_hold),
        .PC_SRC_BRANCH   (pc_src),
        .MEM_ERROR       (mem_err),
        .STALL_COUNT     (stall_cnt),
        .FLUSH_COUNT     (flush_cnt)
    );

    typedef struct {
        logic pw, iw, f1, f2, f3, hold, src, err;
        int   stalls, flushes;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: pipeline mode, consecutive frozen memory cycles, counters.
    typedef enum {MRun, MWait, MHalted} mode_e;
    mode_e m_mode;
    int    m_frozen, m_stalls, m_flushes;
    logic  m_err;

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endfunction

    function automatic int sat_inc(int v);
        return (v >= int'(MAX)) ? int'(MAX) : v + 1;
    endfunction

    // Drive one cycle of inputs and push what the controller should show for it.
    task automatic step(input logic r, input logic a, input logic d, input logic b,
                        input logic lr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic u, input logic h);
        exp_t e;
        logic lu;
        @(posedge clk);
        #1;
        rst = r; acc = a; rdy = d; br = b; ex_rd = lr; ex_rt = ert;
        id_rs = rs; id_rt = rt; uses_rt = u; halt = h;
        e.err = m_err; e.stalls = m_stalls; e.flushes = m_flushes;
        e.pw = 1; e.iw = 1; e.f1 = 0; e.f2 = 0; e.f3 = 0; e.hold = 0; e.src = 0;
        lu = lr && (ert != 0) && ((ert == rs) || (u && ert == rt));
        if (r) begin
            e.pw = 0; e.iw = 0; e.f1 = 1; e.f2 = 1; e.f3 = 1;
            m_mode = MRun; m_frozen = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else if (m_mode == MHalted) begin
            e.pw = 0; e.iw = 0; e.hold = 1;
        end else if (m_mode == MWait) begin
            if (d) begin
                m_mode = MRun; m_frozen = 0;
            end else begin
                e.pw = 0; e.iw = 0; e.hold = 1;
                m_stalls = sat_inc(m_stalls);
                m_frozen++;
                if (m_frozen == int'(TO)) begin
                    m_err = 1; m_mode = MHalted;
                end
            end
        end else if (a && !d) begin
            e.pw = 0; e.iw = 0; e.hold = 1;
            m_stalls = sat_inc(m_stalls);
            m_frozen = 1; m_mode = MWait;
        end else if (b) begin
            e.src = 1; e.f1 = 1; e.f2 = 1; e.f3 = 1;
            m_flushes = sat_inc(m_flushes);
        end else if (lu) begin
            e.pw = 0; e.iw = 0; e.f2 = 1;
            m_stalls = sat_inc(m_stalls);
        end else if (h) begin
            e.pw = 0; e.iw = 0; e.f2 = 1;
            m_mode = MHalted;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Monitor: compare the DUT against the oldest pending expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_write",      16'(pc_write),      16'(e.pw));
            chk("if_id_write",   16'(if_id_write),   16'(e.iw));
            chk("if_id_flush",   16'(if_id_flush),   16'(e.f1));
            chk("id_ex_flush",   16'(id_ex_flush),   16'(e.f2));
            chk("ex_mem_flush",  16'(ex_mem_flush),  16'(e.f3));
            chk("pipe_hold",     16'(pipe_hold),     16'(e.hold));
            chk("pc_src_branch", 16'(pc_src),        16'(e.src));
            chk("mem_error",     16'(mem_err),       16'(e.err));
            chk("stall_count",   16'(stall_cnt),     16'(e.stalls));
            chk("flush_count",   16'(flush_cnt),     16'(e.flushes));
        end
    end

    initial begin
        m_mode = MRun; m_frozen = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        rst = 1; acc = 0; rdy = 1; br = 0; ex_rd = 0; ex_rt = 0;
        id_rs = 0; id_rt = 0; uses_rt = 0; halt = 0;
        @(posedge clk);
        // Reset values and outputs during reset
        step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        // Load-use on rs, then r0 load that must not stall
        step(0, 0, 1, 0, 1, 5'd2, 5'd2, 5'd7, 0, 0);
        idle();
        step(0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
        // Load-use on rt only when rt is a source
        step(0, 0, 1, 0, 1, 5'd3, 5'd1, 5'd3, 0, 0);
        step(0, 0, 1, 0, 1, 5'd3, 5'd1, 5'd3, 1, 0);
        // Branch taken beats concurrent load-use
        step(0, 0, 1, 1, 1, 5'd2, 5'd2, 5'd0, 0, 0);
        idle();
        // Memory wait of three cycles, released on the fourth
        repeat (3) step(0, 1, 0, 1, 1, 5'd2, 5'd2, 5'd0, 0, 1);
        step(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        // Reset during the second memory-wait cycle
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        // Saturation of the stall counter
        repeat (20) step(0, 0, 1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0);
        idle();
        // Timeout into error halt, then inputs ignored until reset
        repeat (TO) step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        repeat (8) step(0, 1, $urandom_range(0, 1), 1, 1, 5'd1, 5'd1, 5'd1, 1, 1);
        step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        // Halt request
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        repeat (3) step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 49) == 0));
        end
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
